com_uart_rx_fifo: RTL
=====================

COM_UART_RX_FIFO -- requirements
Module: com_uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, number of FIFO entries; SHALL be a power of two, 4..256.
REQ-002 Parameter DATA_WIDTH, default 8, width of the received data byte.
REQ-003 clk  input  1  system clock; the block SHALL use only this clock.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 rx_data_in  input  DATA_WIDTH  byte from the UART receiver's data buffer; stable while rx_write_en is high.
REQ-006 rx_write_en  input  1  receiver byte-complete strobe; asynchronous to clk, high for at least one baud period.
REQ-007 rx_valid_packet  input  1  receiver parity status; 1 = parity good; stable while rx_write_en is high.
REQ-008 rd_en  input  1  pop request from the consumer.
REQ-009 data_out  output  DATA_WIDTH  head entry data (show-ahead).
REQ-010 parity_err_out  output  1  head entry parity-error flag.
REQ-011 empty  output  1  FIFO holds no entries.
REQ-012 full  output  1  FIFO holds DEPTH entries.
REQ-013 count  output  log2(DEPTH)+1  current number of entries.
REQ-014 overflow  output  1  sticky flag: a byte was dropped because the FIFO was full.
REQ-015 overflow_clr  input  1  clears overflow.

Function
REQ-016 rx_write_en SHALL pass through a 2-flop synchronizer, then a rising-edge detector, producing a one-clk push pulse.
REQ-017 On the push pulse the block SHALL capture rx_data_in and the inverse of rx_valid_packet into one entry of DATA_WIDTH+1 bits.
REQ-018 The push latency SHALL be fixed: empty deasserts on the 4th clk rising edge after rx_write_en first rises, counting from the first clk edge that samples it high.
REQ-019 Exactly one push SHALL occur per rx_write_en high period, regardless of its length.
REQ-020 data_out/parity_err_out SHALL reflect the entry at the read pointer; both are don't-care while empty=1.
REQ-021 rd_en while empty=0 SHALL pop one entry on that clk edge; rd_en while empty=1 SHALL be ignored with no pointer or count change.
REQ-022 A push while full=1 with no pop SHALL drop the byte, leave pointers and count unchanged, and set overflow on the same edge.
REQ-023 A push and a pop on the same edge while full=1 SHALL both take effect; count stays DEPTH; overflow is not set.
REQ-024 A push and a pop on the same edge while empty=1 SHALL store the byte and ignore the pop; count becomes 1.
REQ-025 A push and a pop on the same edge in any other state SHALL leave count unchanged.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH; full and empty SHALL be derived from count, never from pointer equality alone.
REQ-027 overflow_clr SHALL clear overflow on the next edge; if it coincides with a new drop, overflow SHALL remain 1 (set wins).
REQ-028 count SHALL equal writes accepted minus pops accepted since reset, and SHALL always lie in 0..DEPTH.

Reset
REQ-029 With rst=1 at a clk edge, count, pointers, and overflow SHALL be set to 0, and empty to 1 and full to 0.
REQ-030 With rst=1 at a clk edge, both synchronizer flops and the edge-detect flop SHALL be set to 1, so a receiver strobe already high at reset release produces no push.
REQ-031 Reset asserted mid-operation SHALL discard all stored entries.
REQ-032 Storage array contents need not be reset.

Configuration
REQ-033 Macro UART_RX_PARITY_DROP_EN, when defined: a push with rx_valid_packet=0 SHALL be discarded, with no entry or count change; parity_err_out SHALL be tied to 0.
REQ-034 Macro UART_RX_PARITY_DROP_EN, when undefined: every byte is stored with its parity flag, per REQ-017.

Verification
REQ-035 Reset, then strobe rx_data_in=0x5A with valid=1 -> empty falls 4 clk later; data_out=0x5A; parity_err_out=0; count=1.
REQ-036 Hold rx_write_en high for 100 clk with data 0x33 -> exactly one entry stored; count=1.
REQ-037 Push 16 bytes 0x00..0x0F, then push 0xFF -> full=1; overflow=1; count=16; pops return 0x00..0x0F in order, then empty=1.
REQ-038 When full, push 0xAA while asserting rd_en on the push edge -> count stays 16; overflow stays 0; last pop returns 0xAA.
REQ-039 Push 0xC3 with valid=0 -> macro undefined: entry stored, parity_err_out=1; macro defined: empty stays 1.
REQ-040 Push 3 bytes, assert rst for 1 clk -> empty=1, count=0, overflow=0; then rd_en on empty -> no change.

Source files
------------

// File: rtl/com_uart_rx_fifo_if.sv
// Bus bundle between a UART receiver/consumer pair and com_uart_rx_fifo.
// master: receiver side plus consumer; slave: the FIFO itself.
interface com_uart_rx_fifo_if #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] rx_data_in;
  logic                  rx_write_en;
  logic                  rx_valid_packet;
  logic                  rd_en;
  logic                  overflow_clr;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  parity_err_out;
  logic                  empty;
  logic                  full;
  logic [CW-1:0]         count;
  logic                  overflow;

  modport master (
    output rx_data_in, rx_write_en, rx_valid_packet, rd_en, overflow_clr,
    input  data_out, parity_err_out, empty, full, count, overflow
  );

  modport slave (
    input  rx_data_in, rx_write_en, rx_valid_packet, rd_en, overflow_clr,
    output data_out, parity_err_out, empty, full, count, overflow
  );
endinterface

// File: rtl/com_uart_rx_fifo.sv
// UART receive FIFO: synchronised byte strobe, show-ahead read, sticky overflow.
// Optional macro UART_RX_PARITY_DROP_EN discards bytes that fail parity.
module com_uart_rx_fifo #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  com_uart_rx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q, count_d;
  logic                overflow_q;
  logic                sync1_q, sync2_q, edge_q, push_q;
  logic                push, pop_req, do_write, drop, full_w, empty_w;
  logic [DATA_WIDTH:0] head;

  // Flops preset to 1 so a strobe already high at reset release never pushes.
  // push_q is registered to give a fixed four-edge write latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      edge_q  <= 1'b1;
      push_q  <= 1'b0;
    end else begin
      sync1_q <= bus.rx_write_en;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
      push_q  <= sync2_q & ~edge_q;
    end
  end

`ifdef UART_RX_PARITY_DROP_EN
  assign push               = push_q & bus.rx_valid_packet;
  assign bus.parity_err_out = 1'b0;
`else
  assign push               = push_q;
  assign bus.parity_err_out = head[DATA_WIDTH];
`endif

  assign full_w   = (count_q == DEPTH_C);
  assign empty_w  = (count_q == '0);
  assign pop_req  = bus.rd_en & ~empty_w;
  assign do_write = push & (~full_w | pop_req);
  assign drop     = push & full_w & ~pop_req;

  always_comb begin
    count_d = count_q;
    if (do_write && !pop_req)      count_d = count_q + CW'(1);
    else if (!do_write && pop_req) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_write) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_req)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      if (drop)                  overflow_q <= 1'b1;
      else if (bus.overflow_clr) overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr_q] <= {~bus.rx_valid_packet, bus.rx_data_in};
  end

  assign head         = mem[rd_ptr_q];
  assign bus.data_out = head[DATA_WIDTH-1:0];
  assign bus.empty    = empty_w;
  assign bus.full     = full_w;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
endmodule
